// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; single-cycle ops complete in one edge,
// MUL runs a shift-add loop of DATA_WIDTH_P steps before presenting the result.
module alu_seq #(
  parameter int unsigned DATA_WIDTH_P  = 32,
  parameter int unsigned CNTRL_WIDTH_P = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [CNTRL_WIDTH_P-1:0] i_control,
  input  logic [DATA_WIDTH_P-1:0]  i_a,
  input  logic [DATA_WIDTH_P-1:0]  i_b,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_WIDTH_P-1:0]  o_result,
  output logic                     o_zero,
  output logic                     o_illegal
);

  localparam int unsigned ShW = $clog2(DATA_WIDTH_P);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSltu = 4'b0111;
  localparam logic [3:0] OpMul  = 4'b1000;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpSlt  = 4'b1111;

  logic [1:0]              state_q, state_d;
  logic [DATA_WIDTH_P-1:0] result_q, result_d;
  logic                    illegal_q, illegal_d;
  logic [ShW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH_P-1:0] acc_q, acc_d;
  logic [DATA_WIDTH_P-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH_P-1:0] mplier_q, mplier_d;

  logic [DATA_WIDTH_P-1:0] alu_res;
  logic                    alu_illegal;
  logic                    is_mul;
  logic [ShW-1:0]          shamt;
  logic [DATA_WIDTH_P-1:0] acc_step;
  logic                    accept;

  assign shamt = i_b[ShW-1:0];

  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    is_mul      = 1'b0;
    case (i_control)
      OpAnd:  alu_res = i_a & i_b;
      OpOr:   alu_res = i_a | i_b;
      OpAdd:  alu_res = i_a + i_b;
      OpSub:  alu_res = i_a - i_b;
      OpXor:  alu_res = i_a ^ i_b;
      OpSltu: alu_res = {{(DATA_WIDTH_P-1){1'b0}}, (i_a < i_b)};
      OpSlt:  alu_res = {{(DATA_WIDTH_P-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      OpSll:  alu_res = i_a << shamt;
      OpSrl:  alu_res = i_a >> shamt;
      OpSra:  alu_res = DATA_WIDTH_P'($signed(i_a) >>> shamt);
      OpMul:  is_mul  = 1'b1;
      default: alu_illegal = 1'b1;
    endcase
  end

  assign o_valid = (state_q == StDone);
  assign o_ready = (state_q == StIdle) || ((state_q == StDone) && i_ready);
  assign accept  = i_valid && o_ready;

  // One partial-product step: add the shifted multiplicand when the low multiplier bit is set.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = StMul;
            acc_d    = '0;
            mcand_d  = i_a;
            mplier_d = i_b;
            cnt_d    = ShW'(DATA_WIDTH_P - 1);
          end else begin
            state_d   = StDone;
            result_d  = alu_res;
            illegal_d = alu_illegal;
          end
        end else if ((state_q == StDone) && i_ready) begin
          state_d = StIdle;
        end
      end
      StMul: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - ShW'(1);
        if (cnt_q == '0) begin
          state_d   = StDone;
          result_d  = acc_step;
          illegal_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      result_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
    end
  end

  assign o_result  = result_q;
  assign o_zero    = (result_q == '0);
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed and random ops against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          i_valid;
  logic          o_ready;
  logic [3:0]    i_control;
  logic [W-1:0]  i_a;
  logic [W-1:0]  i_b;
  logic          o_valid;
  logic          i_ready;
  logic [W-1:0]  o_result;
  logic          o_zero;
  logic          o_illegal;

  int vectors;
  int miscompares;

  alu_seq #(
    .DATA_WIDTH_P (W),
    .CNTRL_WIDTH_P(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_control(i_control),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_illegal(o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: results straight from the opcode table using plain arithmetic.
  function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill);
    int unsigned sh;
    logic [63:0] prod;
    logic [W-1:0] fill;
    sh   = int'(b % 32);
    ill  = 1'b0;
    r    = '0;
    case (c)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  r = a + b;
      4'd6:  r = a - b;
      4'd3:  r = a ^ b;
      4'd7:  r = (a < b) ? 32'd1 : 32'd0;
      4'd15: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd4:  r = a << sh;
      4'd5:  r = a >> sh;
      4'd13: begin
        fill = a[W-1] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
        r    = (a >> sh) | fill;
      end
      4'd8: begin
        prod = {32'd0, a} * {32'd0, b};
        r    = prod[31:0];
      end
      default: ill = 1'b1;
    endcase
  endfunction

  // Issues one op from IDLE, waits (bounded) for o_valid, samples, then consumes it.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic ill, output logic zero,
                       output int lat, output bit ready_seen);
    @(negedge clk);
    i_valid   = 1'b1;
    i_control = c;
    i_a       = a;
    i_b       = b;
    i_ready   = 1'b0;
    @(posedge clk);
    #1;
    i_valid    = 1'b0;
    i_control  = 4'($urandom);
    i_a        = $urandom;
    i_b        = $urandom;
    lat        = 1;
    ready_seen = 1'b0;
    while (!o_valid && lat < 200) begin
      if (o_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    res  = o_result;
    ill  = o_illegal;
    zero = o_zero;
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    i_valid   = 1'b1;
    i_control = 4'd2;
    i_a       = 32'd7;
    i_b       = 32'd9;
    i_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors += 5;
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got=%b want=0", o_valid);
    end
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got=%b want=1", o_ready);
    end
    if (o_result !== 32'd0) begin
      miscompares++; $display("FAIL reset_result got=%h want=0", o_result);
    end
    if (o_zero !== 1'b1) begin
      miscompares++; $display("FAIL reset_zero got=%b want=1", o_zero);
    end
    if (o_illegal !== 1'b0) begin
      miscompares++; $display("FAIL reset_illegal got=%b want=0", o_illegal);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic run_dir(input string name, input logic [3:0] c, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    logic [W-1:0] res, exp_r;
    logic ill, zero, exp_i;
    int lat, exp_lat;
    bit rs;
    model(c, a, b, exp_r, exp_i);
    exp_lat = (c == 4'd8) ? W + 1 : 1;
    issue(c, a, b, res, ill, zero, lat, rs);
    vectors += 4;
    if (res !== exp_r) begin
      miscompares++; $display("FAIL %s result got=%h want=%h", name, res, exp_r);
    end
    if (ill !== exp_i) begin
      miscompares++; $display("FAIL %s illegal got=%b want=%b", name, ill, exp_i);
    end
    if (zero !== (exp_r == 0)) begin
      miscompares++; $display("FAIL %s zero got=%b want=%b", name, zero, exp_r == 0);
    end
    if (lat != exp_lat) begin
      miscompares++; $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
    end
    if (c == 4'd8) begin
      vectors++;
      if (rs) begin
        miscompares++; $display("FAIL %s ready_in_mul got=1 want=0", name);
      end
    end
  endtask

  task automatic test_legacy;
    run_dir("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1);
    run_dir("sub",      4'b0110, 32'd5, 32'd7);
    run_dir("sltu",     4'b0111, 32'h8000_0000, 32'd1);
    run_dir("and",      4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    run_dir("or",       4'b0001, 32'hF000_0001, 32'h0000_1000);
  endtask

  task automatic test_new_ops;
    run_dir("slt",     4'b1111, 32'h8000_0000, 32'd1);
    run_dir("sra",     4'b1101, 32'h8000_0000, 32'h24);
    run_dir("xor",     4'b0011, 32'h0000_F0F0, 32'h0000_FF00);
    run_dir("illegal", 4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
    run_dir("sll",     4'b0100, 32'h8000_0001, 32'hFFFF_FFE1);
    run_dir("srl",     4'b0101, 32'h8000_0000, 32'd31);
  endtask

  task automatic test_mul;
    run_dir("mul_dir", 4'b1000, 32'h0001_0001, 32'h0001_0001);
    run_dir("mul_neg", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) run_dir("mul_rand", 4'b1000, $urandom, $urandom);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) run_dir("rand", 4'($urandom), $urandom, $urandom);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] exp1, exp2;
    logic ill;
    model(4'd2, 32'd100, 32'd23, exp1, ill);
    model(4'd6, 32'd10, 32'd40, exp2, ill);
    @(negedge clk);
    i_valid = 1'b1; i_control = 4'd2; i_a = 32'd100; i_b = 32'd23; i_ready = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (o_valid !== 1'b1 || o_result !== exp1) begin
      miscompares++; $display("FAIL bp_first got=%b/%h want=1/%h", o_valid, o_result, exp1);
    end
    @(negedge clk);
    i_control = 4'd6; i_a = 32'd10; i_b = 32'd40;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      vectors += 2;
      if (o_result !== exp1 || o_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold cycle=%0d got=%b/%h want=1/%h", k, o_valid, o_result, exp1);
      end
      if (o_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_ready cycle=%0d got=%b want=0", k, o_ready);
      end
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (o_valid !== 1'b1 || o_result !== exp2) begin
      miscompares++; $display("FAIL bp_swap got=%b/%h want=1/%h", o_valid, o_result, exp2);
    end
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_drain got=%b want=0", o_valid);
    end
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] expq[$];
    logic [W-1:0] a, b, r, e;
    logic ill;
    for (int k = 0; k < 4; k++) begin
      a = $urandom; b = $urandom;
      model(4'd2, a, b, r, ill);
      expq.push_back(r);
      @(negedge clk);
      i_valid = 1'b1; i_control = 4'd2; i_a = a; i_b = b; i_ready = 1'b1;
      @(posedge clk);
      #1;
      e = expq.pop_front();
      vectors++;
      if (o_valid !== 1'b1 || o_result !== e) begin
        miscompares++; $display("FAIL b2b_%0d got=%b/%h want=1/%h", k, o_valid, o_result, e);
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL b2b_drain got=%b want=0", o_valid);
    end
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul;
    bit seen;
    run_dir("pre_add", 4'd2, 32'd1, 32'd1);
    @(negedge clk);
    i_valid = 1'b1; i_control = 4'd8; i_a = 32'd12345; i_b = 32'd678; i_ready = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors += 4;
    if (o_valid !== 1'b0) begin
      miscompares++; $display("FAIL rst_mul_valid got=%b want=0", o_valid);
    end
    if (o_result !== 32'd0) begin
      miscompares++; $display("FAIL rst_mul_result got=%h want=0", o_result);
    end
    if (o_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_mul_ready got=%b want=1", o_ready);
    end
    if (o_zero !== 1'b1) begin
      miscompares++; $display("FAIL rst_mul_zero got=%b want=1", o_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL rst_mul_ghost got=1 want=0");
    end
    run_dir("post_add", 4'd2, 32'd2, 32'd3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_legacy();
    test_new_ops();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
